dcount_ctrl: RTL and testbench

DCOUNT_CTRL -- requirements
Module: dcount_ctrl

---
 rtl/dcount_ctrl.sv | 144 ++++++++++++++
 tb/tb_dcount_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dcount_ctrl.sv
// Two-requester arbitrated down-counter: grants the shared counter, loads, counts down by STEP, pulses done.
// Optional macro DCOUNT_CTRL_PAUSE_EN adds a pause input that freezes counting.
module dcount_ctrl #(
  parameter int W    = 8,
  parameter int STEP = 5
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] val0,
  input  logic [W-1:0] val1,
`ifdef DCOUNT_CTRL_PAUSE_EN
  input  logic         pause,
`endif
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] STEP_C = W'(STEP);

  state_t       state_r, state_s;
  logic         owner_r, owner_s;
  logic         last_r, last_s;
  logic [W-1:0] q_r, q_s;
  logic         owner_req_s;
  logic         stall_s;
  logic         gnt0_r, gnt1_r, busy_r, done_r, done_id_r;
  logic         gnt0_s, gnt1_s, busy_s, done_s, done_id_s;

`ifdef DCOUNT_CTRL_PAUSE_EN
  assign stall_s = pause;
`else
  assign stall_s = 1'b0;
`endif

  // Next-state, counter and arbitration logic; outputs are precomputed for the output registers.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    last_s      = last_r;
    q_s         = q_r;
    owner_req_s = owner_r ? req1 : req0;
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          owner_s = ~last_r;
          state_s = LOAD;
        end else if (req0) begin
          owner_s = 1'b0;
          state_s = LOAD;
        end else if (req1) begin
          owner_s = 1'b1;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (!owner_req_s) begin
          state_s = IDLE;
          last_s  = owner_r;
        end else begin
          q_s     = owner_r ? val1 : val0;
          state_s = COUNT;
        end
      end
      COUNT: begin
        // Abort takes priority over pause so a paused owner can still withdraw.
        if (!owner_req_s) begin
          state_s = IDLE;
          last_s  = owner_r;
        end else if (stall_s) begin
          state_s = COUNT;
        end else if (q_r >= STEP_C) begin
          q_s = q_r - STEP_C;
        end else begin
          state_s = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
        last_s  = owner_r;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s    = (state_s != IDLE);
    gnt0_s    = busy_s && !owner_s;
    gnt1_s    = busy_s && owner_s;
    done_s    = (state_s == DONE);
    if (done_s) begin
      done_id_s = owner_s;
    end else begin
      done_id_s = 1'b0;
    end
  end

  // State, counter and registered outputs; reset leaves requester 0 winning the first tie.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r   <= IDLE;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      q_r       <= '0;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      owner_r   <= owner_s;
      last_r    <= last_s;
      q_r       <= q_s;
      gnt0_r    <= gnt0_s;
      gnt1_r    <= gnt1_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      done_id_r <= done_id_s;
    end
  end

  assign gnt0    = gnt0_r;
  assign gnt1    = gnt1_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign done_id = done_id_r;
  assign q       = q_r;

endmodule

// File: tb/tb_dcount_ctrl.sv
// Directed self-checking bench for dcount_ctrl (W=8, STEP=5); pause steps run when DCOUNT_CTRL_PAUSE_EN is defined.
module tb_dcount_ctrl;
  logic       clk;
  logic       rst_b;
  logic       req0, req1;
  logic [7:0] val0, val1;
`ifdef DCOUNT_CTRL_PAUSE_EN
  logic       pause;
`endif
  logic       gnt0, gnt1, busy, done, done_id;
  logic [7:0] q;

  int tests = 0;
  int fails = 0;

  dcount_ctrl #(.W(8), .STEP(5)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .req0    (req0),
    .req1    (req1),
    .val0    (val0),
    .val1    (val1),
`ifdef DCOUNT_CTRL_PAUSE_EN
    .pause   (pause),
`endif
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [7:0] exp_q);
    chk({tag, ".q"}, 32'(q), 32'(exp_q));
    chk({tag, ".gnt0"}, 32'(gnt0), 32'd0);
    chk({tag, ".gnt1"}, 32'(gnt1), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".done_id"}, 32'(done_id), 32'd0);
  endtask

  initial begin
    logic [7:0] seq_q [4];
    logic       exp_owner [3];
    logic [7:0] exp_val;

    rst_b = 1'b0; req0 = 1'b0; req1 = 1'b0; val0 = 8'd0; val1 = 8'd0;
`ifdef DCOUNT_CTRL_PAUSE_EN
    pause = 1'b0;
`endif
    #1;
    chk_idle_outputs("reset", 8'd0);
    tick(); tick();
    rst_b = 1'b1;

    // Basic countdown 20 -> 0
    val0 = 8'd20; req0 = 1'b1;
    tick();
    chk("t1.load.gnt0", 32'(gnt0), 32'd1);
    chk("t1.load.busy", 32'(busy), 32'd1);
    seq_q = '{8'd20, 8'd15, 8'd10, 8'd5};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1.count.q", 32'(q), 32'(seq_q[i]));
      chk("t1.count.done", 32'(done), 32'd0);
    end
    tick();
    chk("t1.last.q", 32'(q), 32'd0);
    chk("t1.last.done", 32'(done), 32'd0);
    tick();
    chk("t1.done", 32'(done), 32'd1);
    chk("t1.done_id", 32'(done_id), 32'd0);
    chk("t1.done.q", 32'(q), 32'd0);
    chk("t1.done.gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    tick();
    chk_idle_outputs("t1.idle", 8'd0);

    // Remainder case 23 -> 3
    val0 = 8'd23; req0 = 1'b1;
    tick();
    chk("t2.load.gnt0", 32'(gnt0), 32'd1);
    seq_q = '{8'd23, 8'd18, 8'd13, 8'd8};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2.count.q", 32'(q), 32'(seq_q[i]));
    end
    tick();
    chk("t2.last.q", 32'(q), 32'd3);
    tick();
    chk("t2.done", 32'(done), 32'd1);
    chk("t2.done.q", 32'(q), 32'd3);
    req0 = 1'b0;
    val0 = 8'd99;
    tick();
    chk_idle_outputs("t2.idle", 8'd3);

    // Zero load value: a single COUNT cycle
    val0 = 8'd0; req0 = 1'b1;
    tick();
    chk("t3.load.gnt0", 32'(gnt0), 32'd1);
    tick();
    chk("t3.count.q", 32'(q), 32'd0);
    chk("t3.count.done", 32'(done), 32'd0);
    tick();
    chk("t3.done", 32'(done), 32'd1);
    chk("t3.done.q", 32'(q), 32'd0);
    req0 = 1'b0;
    tick();
    chk("t3.idle.busy", 32'(busy), 32'd0);

    // Round robin with both requests held from reset
    rst_b = 1'b0;
    #1;
    chk_idle_outputs("t4.reset", 8'd0);
    req0 = 1'b1; req1 = 1'b1; val0 = 8'd3; val1 = 8'd4;
    tick();
    rst_b = 1'b1;
    exp_owner = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      exp_val = exp_owner[k] ? 8'd4 : 8'd3;
      tick();
      chk("t4.load.gnt0", 32'(gnt0), 32'(!exp_owner[k]));
      chk("t4.load.gnt1", 32'(gnt1), 32'(exp_owner[k]));
      tick();
      chk("t4.count.q", 32'(q), 32'(exp_val));
      chk("t4.count.excl", 32'(gnt0 & gnt1), 32'd0);
      tick();
      chk("t4.done", 32'(done), 32'd1);
      chk("t4.done_id", 32'(done_id), 32'(exp_owner[k]));
      chk("t4.done.excl", 32'(gnt0 & gnt1), 32'd0);
      tick();
      chk("t4.idle.busy", 32'(busy), 32'd0);
      chk("t4.idle.done", 32'(done), 32'd0);
    end

    // Abort of owner 0 at q=10, pending requester 1 granted next
    rst_b = 1'b0;
    #1;
    rst_b = 1'b1;
    val0 = 8'd20; val1 = 8'd6;
    tick();
    chk("t5.load.gnt0", 32'(gnt0), 32'd1);
    tick(); tick(); tick();
    chk("t5.pre.q", 32'(q), 32'd10);
    req0 = 1'b0;
    tick();
    chk_idle_outputs("t5.abort", 8'd10);
    tick();
    chk("t5.load.gnt1", 32'(gnt1), 32'd1);
    chk("t5.load.q", 32'(q), 32'd10);
    tick();
    chk("t5.count.q0", 32'(q), 32'd6);
    tick();
    chk("t5.count.q1", 32'(q), 32'd1);
    tick();
    chk("t5.done", 32'(done), 32'd1);
    chk("t5.done_id", 32'(done_id), 32'd1);
    req1 = 1'b0;
    tick();
    chk("t5.idle.busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-countdown at q=15
    val0 = 8'd20; req0 = 1'b1;
    tick(); tick(); tick();
    chk("t6.pre.q", 32'(q), 32'd15);
    #3;
    rst_b = 1'b0;
    #1;
    chk_idle_outputs("t6.async", 8'd0);
    req0 = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
    chk("t6.after.busy", 32'(busy), 32'd0);

`ifdef DCOUNT_CTRL_PAUSE_EN
    // Pause holds q and state for three cycles at q=10
    val0 = 8'd20; req0 = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t7.pre.q", 32'(q), 32'd10);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7.pause.q", 32'(q), 32'd10);
      chk("t7.pause.busy", 32'(busy), 32'd1);
    end
    pause = 1'b0;
    tick();
    chk("t7.resume.q5", 32'(q), 32'd5);
    tick();
    chk("t7.resume.q0", 32'(q), 32'd0);
    tick();
    chk("t7.done", 32'(done), 32'd1);
    req0 = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
